// File: rtl/axi_lite_slave_mem_if.sv
// AXI4-Lite bus bundle between a master and the register-memory slave.
// Address/data widths follow the slave's parameters; strobes are one bit per byte.
interface axi_lite_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a DEPTH-word register memory with byte strobes.
// Independent read and write FSMs, one outstanding transaction per channel.
module axi_lite_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  axi_lite_slave_mem_if.slave   bus
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DEPTH * 4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_WAIT_DATA, WR_WAIT_ADDR, WR_RESP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_DATA} rd_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write channel ----------------
  wr_state_t             wr_state_reg, wr_state_next;
  logic                  awready_reg, wready_reg, bvalid_reg;
  logic [1:0]            bresp_reg;
  logic [ADDR_WIDTH-1:0] awaddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [NUM_LANES-1:0]  wstrb_reg;

  logic                  aw_hs, w_hs, wr_commit, latch_addr, latch_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_LANES-1:0]  wr_strb;
  logic                  wr_in_range;
  logic [IDX_W-1:0]      wr_idx;

  assign aw_hs = bus.awvalid && awready_reg;
  assign w_hs  = bus.wvalid && wready_reg;

  // Whichever half arrived first is taken from the latch, the other straight off the bus.
  assign wr_addr     = (wr_state_reg == WR_WAIT_DATA) ? awaddr_reg : bus.awaddr;
  assign wr_data     = (wr_state_reg == WR_WAIT_ADDR) ? wdata_reg  : bus.wdata;
  assign wr_strb     = (wr_state_reg == WR_WAIT_ADDR) ? wstrb_reg  : bus.wstrb;
  assign wr_in_range = (wr_addr < ADDR_LIMIT);
  assign wr_idx      = wr_addr[IDX_W+1:2];

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_commit     = 1'b0;
    latch_addr    = 1'b0;
    latch_data    = 1'b0;
    case (wr_state_reg)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit     = 1'b1;
          wr_state_next = WR_RESP;
        end else if (aw_hs) begin
          latch_addr    = 1'b1;
          wr_state_next = WR_WAIT_DATA;
        end else if (w_hs) begin
          latch_data    = 1'b1;
          wr_state_next = WR_WAIT_ADDR;
        end
      end
      WR_WAIT_DATA: begin
        if (w_hs) begin
          wr_commit     = 1'b1;
          wr_state_next = WR_RESP;
        end
      end
      WR_WAIT_ADDR: begin
        if (aw_hs) begin
          wr_commit     = 1'b1;
          wr_state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid_reg && bus.bready) wr_state_next = WR_IDLE;
      end
      default: wr_state_next = WR_IDLE;
    endcase
  end

  // Ready/valid flags are registered copies of what the next state wants.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state_reg <= WR_IDLE;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      awready_reg  <= (wr_state_next == WR_IDLE) || (wr_state_next == WR_WAIT_ADDR);
      wready_reg   <= (wr_state_next == WR_IDLE) || (wr_state_next == WR_WAIT_DATA);
      bvalid_reg   <= (wr_state_next == WR_RESP);
      if (latch_addr) awaddr_reg <= bus.awaddr;
      if (latch_data) begin
        wdata_reg <= bus.wdata;
        wstrb_reg <= bus.wstrb;
      end
      if (wr_commit) bresp_reg <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  logic [NUM_LANES-1:0] lane_we;
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_we
    assign lane_we[gi] = wr_commit && wr_in_range && wr_strb[gi];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (lane_we[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_t             rd_state_reg, rd_state_next;
  logic                  arready_reg, rvalid_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            rresp_reg;
  logic                  ar_hs, rd_in_range;
  logic [IDX_W-1:0]      rd_idx;

  assign ar_hs       = bus.arvalid && arready_reg;
  assign rd_in_range = (bus.araddr < ADDR_LIMIT);
  assign rd_idx      = bus.araddr[IDX_W+1:2];

  always_comb begin
    rd_state_next = rd_state_reg;
    case (rd_state_reg)
      RD_IDLE: if (ar_hs) rd_state_next = RD_DATA;
      RD_DATA: if (rvalid_reg && bus.rready) rd_state_next = RD_IDLE;
      default: rd_state_next = RD_IDLE;
    endcase
  end

  // Sampling mem here with non-blocking writes gives pre-write data on a same-edge collision.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state_reg <= RD_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
      rresp_reg    <= RESP_OKAY;
    end else begin
      rd_state_reg <= rd_state_next;
      arready_reg  <= (rd_state_next == RD_IDLE);
      rvalid_reg   <= (rd_state_next == RD_DATA);
      if (ar_hs) begin
        rdata_reg <= rd_in_range ? mem[rd_idx] : '0;
        rresp_reg <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign bus.awready = awready_reg;
  assign bus.wready  = wready_reg;
  assign bus.bvalid  = bvalid_reg;
  assign bus.bresp   = bresp_reg;
  assign bus.arready = arready_reg;
  assign bus.rvalid  = rvalid_reg;
  assign bus.rdata   = rdata_reg;
  assign bus.rresp   = rresp_reg;
endmodule

// File: doc/axi_lite_slave_mem.md
# axi_lite_slave_mem

AXI4-Lite slave holding a word-addressed register memory. It sits directly downstream of `axi_lite_dut` and terminates the AXI4-Lite bus that the master drives through `bfm.axi_if`. It gives the master real write-then-read targets, byte-strobe semantics and SLVERR responses for the environment's checks. It has independent read and write state machines; each channel allows one outstanding transaction.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, data width; only 32 is supported (4 byte lanes)
- DEPTH, 16, number of 32-bit words; must be a power of 2
- aclk  in  1  the only clock; all logic is on the rising edge
- areset  in  1  reset, asynchronous and active-high
- awaddr  in  ADDR_WIDTH  write address
- awvalid / awready  in / out  1  write-address handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  4  byte enables; bit i enables wdata[8i+7:8i]
- wvalid / wready  in / out  1  write-data handshake
- bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- bvalid / bready  out / in  1  write-response handshake
- araddr  in  ADDR_WIDTH  read address
- arvalid / arready  in / out  1  read-address handshake
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
- rvalid / rready  out / in  1  read-data handshake

## Operation
- Word index is addr[log2(DEPTH)+1:2].
- addr[1:0] is ignored, so unaligned accesses are treated as aligned.
- An address is out of range when addr >= DEPTH*4.
  - Out-of-range write: memory is not modified and the response is SLVERR.
  - Out-of-range read: rdata = 0 and the response is SLVERR.
- Write FSM states: WR_IDLE, WR_WAIT_DATA, WR_WAIT_ADDR, WR_RESP.
  - WR_IDLE: awready = 1 and wready = 1.
    - AW and W handshake in the same cycle: commit the write, go to WR_RESP.
    - AW handshake only: latch awaddr, go to WR_WAIT_DATA.
    - W handshake only: latch wdata and wstrb, go to WR_WAIT_ADDR.
  - WR_WAIT_DATA: awready = 0, wready = 1. On W handshake, commit the write and go to WR_RESP.
  - WR_WAIT_ADDR: awready = 1, wready = 0. On AW handshake, commit the write and go to WR_RESP.
  - WR_RESP: awready = 0, wready = 0, bvalid = 1, bresp held stable. On bvalid && bready, return to WR_IDLE.
- Commit writes only the byte lanes with wstrb = 1. wstrb = 0 is legal: it gives an OKAY response with no change to memory.
- Read FSM states: RD_IDLE, RD_DATA.
  - RD_IDLE: arready = 1. On AR handshake, register rdata and rresp, go to RD_DATA.
  - RD_DATA: arready = 0, rvalid = 1. rdata and rresp are held stable until rready. On rvalid && rready, return to RD_IDLE.
- Read and write FSMs run fully independently.
- A read and a write committing to the same word on the same edge: the read returns the pre-write value.

## Timing
- areset asserted forces, immediately and without waiting for a clock edge:
  - both FSMs to IDLE
  - every output to 0: awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata
  - every memory word to 0
- Ready outputs are registered. The first edge after areset deasserts raises awready, wready and arready to 1.
- Write latency:
  - Final AW/W handshake at edge N: memory is updated at edge N and bvalid is 1 from edge N.
  - B handshake at edge M: awready and wready are 1 from edge M, so the next AW/W handshake can occur at edge M+1 at the earliest.
- Read latency:
  - AR handshake at edge N: rvalid = 1 and rdata is valid from edge N.
  - R handshake at edge M: arready = 1 from edge M.
- Single-channel throughput: one transaction per 2 cycles when ready and valid are held high.
- bvalid and rvalid never drop before their handshake completes.
- The master may drop awvalid, wvalid or arvalid while the matching ready is low; the slave takes no action on this.
- areset asserted mid-transaction (for example in WR_WAIT_DATA or RD_DATA) aborts the transaction. No response is issued and memory is cleared.

## Test plan
- Reset then idle: areset pulsed for 3 cycles -> all outputs 0 during reset; awready = wready = arready = 1 one edge after release; reading addr 0x0 returns 0x00000000 with rresp OKAY.
- Full write and readback: AW+W in the same cycle, addr 0x04, data 0xDEADBEEF, wstrb 4'hF -> bvalid next cycle with bresp 2'b00; read of 0x04 -> rdata 0xDEADBEEF, rresp 2'b00.
- Strobe and ordering: W (data 0x11223344, wstrb 4'b0101) 3 cycles before AW to 0x08, which holds 0xAAAAAAAA -> FSM passes through WR_WAIT_ADDR; readback 0xAA22AA44.
- Out of range: write to 0x40 with DEPTH = 16 -> bresp 2'b10 and no word changes; read of 0x40 -> rdata 0, rresp 2'b10.
- Backpressure: bready and rready held low for 5 cycles -> bvalid, rvalid, rdata and resp stay stable and arready stays 0; the next AR is accepted only after the R handshake.
- Collision and reset mid-operation: same-edge read and write to 0x0C (old value 0x1, new value 0x2) -> read returns 0x1 and a later read returns 0x2; areset asserted in WR_WAIT_DATA -> bvalid is never asserted and word 0x0C reads 0.
